alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Upstream companion to the ALU stage. Accepts tagged operations over a valid/ready stream and queues them.
- Issues queued operations into the ALU (cmd/a/b/en), which has no backpressure.
- Captures each returning result on the ALU ready pulse, pairs it with its tag, and presents it on a valid/ready output stream.
- Credit control guarantees no ALU result is ever dropped. A flush FSM supports pipeline abort.

Parameters:
- WIDTH, 16, operand/result width; must equal the ALU's WIDTH.
- TAG_W, 4, tag width carried alongside each operation.
- IN_DEPTH, 4, operation queue depth (power of 2, ≥2).
- OUT_DEPTH, 4, result queue depth and issue-credit limit (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- in_cmd  in  3  opcode: 0 add, 1 sub, 2 mul, 3 mod, 4 or
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- in_tag  in  TAG_W  user tag, returned with the result
- flush  in  1  single-cycle pulse; abort all queued and in-flight work
- alu_cmd  out  3  to ALU cmd
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_en  out  1  to ALU en; one operation per high cycle
- alu_result  in  WIDTH  from ALU result
- alu_ready  in  1  from ALU ready; one pulse per issued operation, in order
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  WIDTH  result value
- res_tag  out  TAG_W  tag of the originating operation
- busy  out  1  any work queued, in flight or unread, or state ≠ RUN

Behaviour:
- Reset (reset=0): both queues empty, inflight=0, state=RUN.
  - Output reset values: in_ready=1, alu_en=0, alu_cmd/a/b=0, res_valid=0, res_data=0, res_tag=0, busy=0.
- Input queue: accept on in_valid & in_ready.
  - in_ready = !in_q_full & state==RUN.
  - Enqueue and dequeue in the same cycle are allowed when full.
- Issue condition (registered, 1 cycle after the issue decision): state==RUN & !in_q_empty & (inflight + out_q_count) < OUT_DEPTH.
  - On issue: pop in_q; drive alu_* for exactly one cycle with alu_en=1; push the tag into the tag FIFO (depth OUT_DEPTH); inflight += 1.
  - When not issuing: alu_en=0 and alu_cmd/a/b hold their last values.
  - Back-to-back issue is supported: one operation per cycle.
- Return: on alu_ready=1, pop the tag FIFO and push {alu_result, tag} into out_q; inflight -= 1.
  - Simultaneous issue and return: inflight is unchanged.
  - The credit rule makes out_q overflow impossible. The verifier asserts this.
  - An alu_ready pulse with inflight==0 is a protocol error; assertion only, the pulse is ignored.
- Output: res_valid = !out_q_empty; res_data/res_tag are the out_q head (first-word fall-through); pop on res_valid & res_ready.
- Ordering: results are returned strictly in issue order. The ALU latency (2 cycles from en to ready) is not hard-coded; only alu_ready is used.
- FSM states: RUN, DRAIN.
  - RUN → DRAIN on flush=1: in_q and out_q cleared in the same cycle; issue blocked from that cycle; in_ready=0.
  - DRAIN: alu_ready pulses pop the tag FIFO and decrement inflight, but nothing is pushed to out_q; res_valid=0.
  - DRAIN → RUN when inflight==0 (next cycle). flush in DRAIN is ignored.
  - flush with inflight==0 still passes through DRAIN for exactly 1 cycle.
- opcodes 5–7: forwarded unchanged; the ALU treats them as OR.
- Reset mid-operation: all state discarded immediately; in-flight ALU results arriving afterwards are ignored. The ALU is reset by the same reset.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- Defined: adds outputs stat_issued[31:0], stat_completed[31:0] and stat_flushed[31:0].
  - stat_issued counts alu_en cycles.
  - stat_completed counts res handshakes.
  - stat_flushed counts operations discarded by flush, including queued and in-flight ones.
  - All three wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg:
  - cmd_t enum (CMD_ADD=0, CMD_SUB=1, CMD_MUL=2, CMD_MOD=3, CMD_OR=4).
  - seq_state_t enum (RUN, DRAIN).
  - Parameterised op struct helper widths.
- Sub-module seq_fifo: synchronous FWFT FIFO with DATA_W and DEPTH parameters, plus clear, count, full and empty.
  - Instantiated three times: in_q, tag FIFO, out_q.

Test Plan:
- Single op: a=7, b=5, cmd=0, tag=3 → alu_en 1 cycle; res_valid with res_data=12, res_tag=3; busy falls after the pop.
- Stream of 8 ops (cmd 0..4, tags 0..7) with res_ready=1 → back-to-back alu_en; results in order, e.g. 9*3=27, 10%4=2, 0x0F0|0x00F=0x0FF.
- res_ready=0 with 6 ops offered → exactly 4 issued (OUT_DEPTH credit) and alu_en stalls. Release res_ready → remaining 2 issue, all 6 return in order, no loss.
- flush the cycle after 2 issues with 3 queued → no res_valid for any of the 5; in_ready=0 until both alu_ready pulses arrive; next op tag=9 returns correctly.
- reset=0 asserted mid-stream → all outputs at reset values the next cycle; a subsequent op a=0xFFFF, b=1, cmd=0 → res_data=0x0000.
- ALU_SEQ_STATS_EN build, rerun the flush scenario → stat_issued=3, stat_completed=1, stat_flushed=5.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and helper widths for the ALU sequencer.
// Optional statistics counters are enabled with the ALU_SEQ_STATS_EN macro.
package alu_seq_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_ADD = 3'd0,
        CMD_SUB = 3'd1,
        CMD_MUL = 3'd2,
        CMD_MOD = 3'd3,
        CMD_OR  = 3'd4
    } cmd_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } seq_state_t;

    // Packed operation width: {cmd, a, b, tag}
    function automatic int op_w(input int width, input int tag_w);
        return CMD_W + 2 * width + tag_w;
    endfunction

    // Packed result width: {data, tag}
    function automatic int res_w(input int width, input int tag_w);
        return width + tag_w;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Synchronous first-word-fall-through FIFO with clear, count, full and empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module seq_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_MAX);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage array write port (contents need no reset)
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Front end for the ALU stage: queues tagged operations, issues them under
// credit control so no result can be lost, and returns results with tags in
// issue order. A flush aborts all queued and in-flight work.
// Define ALU_SEQ_STATS_EN to add issued/completed/flushed counters.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int TAG_W     = 4,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cmd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [2:0]       alu_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_completed,
    output logic [31:0]      stat_flushed
`endif
);

    localparam int OP_W   = op_w(WIDTH, TAG_W);
    localparam int RES_W  = res_w(WIDTH, TAG_W);
    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int CW     = $clog2(OUT_DEPTH) + 1;
    localparam logic [CW-1:0] INF_ONE    = 1;
    localparam logic [CW:0]   CREDIT_MAX = OUT_DEPTH[CW:0];

    seq_state_t state_reg, state_next;

    logic [OP_W-1:0]  in_q_head;
    logic [IN_CW-1:0] in_q_count;
    logic             in_q_full, in_q_empty;
    logic [TAG_W-1:0] tag_q_head;
    logic [CW-1:0]    tag_q_count;
    logic             tag_q_full, tag_q_empty;
    logic [RES_W-1:0] out_q_head;
    logic [CW-1:0]    out_q_count;
    logic             out_q_full, out_q_empty;

    logic [2:0]       head_cmd;
    logic [WIDTH-1:0] head_a, head_b;
    logic [TAG_W-1:0] head_tag;

    logic [CW-1:0]    inflight_reg;
    logic [CW:0]      credit_used;
    logic             in_push, issue, ret, out_push, res_pop, flush_now, run_st;

    logic             alu_en_reg;
    logic [2:0]       alu_cmd_reg;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg;

    assign run_st    = (state_reg == RUN);
    assign flush_now = flush & run_st;
    assign in_ready  = ~in_q_full & run_st & ~flush;
    assign in_push   = in_valid & in_ready;
    assign res_pop   = res_valid & res_ready;
    assign ret       = alu_ready & (inflight_reg != '0);
    assign out_push  = ret & run_st & ~flush;

    // A result popped this cycle frees its slot at the same edge, which keeps
    // back-to-back issue going with a 2-cycle ALU and a 4-entry result queue.
    assign credit_used = {1'b0, inflight_reg} + {1'b0, out_q_count} - {{CW{1'b0}}, res_pop};
    assign issue       = run_st & ~flush & ~in_q_empty & (credit_used < CREDIT_MAX);

    assign {head_cmd, head_a, head_b, head_tag} = in_q_head;

    seq_fifo #(.DATA_W(OP_W), .DEPTH(IN_DEPTH)) u_in_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush_now),
        .push      (in_push),
        .push_data ({in_cmd, in_a, in_b, in_tag}),
        .pop       (issue),
        .head      (in_q_head),
        .count     (in_q_count),
        .full      (in_q_full),
        .empty     (in_q_empty)
    );

    // Tags of issued operations; never flushed, in-flight returns still pop it
    seq_fifo #(.DATA_W(TAG_W), .DEPTH(OUT_DEPTH)) u_tag_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (issue),
        .push_data (head_tag),
        .pop       (ret),
        .head      (tag_q_head),
        .count     (tag_q_count),
        .full      (tag_q_full),
        .empty     (tag_q_empty)
    );

    seq_fifo #(.DATA_W(RES_W), .DEPTH(OUT_DEPTH)) u_out_q (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush_now),
        .push      (out_push),
        .push_data ({alu_result, tag_q_head}),
        .pop       (res_pop),
        .head      (out_q_head),
        .count     (out_q_count),
        .full      (out_q_full),
        .empty     (out_q_empty)
    );

    assign res_valid = ~out_q_empty;
    assign res_data  = out_q_empty ? '0 : out_q_head[RES_W-1:TAG_W];
    assign res_tag   = out_q_empty ? '0 : out_q_head[TAG_W-1:0];
    assign busy      = ~in_q_empty | (inflight_reg != '0) | ~out_q_empty | ~run_st;

    assign alu_en  = alu_en_reg;
    assign alu_cmd = alu_cmd_reg;
    assign alu_a   = alu_a_reg;
    assign alu_b   = alu_b_reg;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= RUN;
        else        state_reg <= state_next;
    end

    // Next state: flush enters DRAIN, leave once nothing is in flight
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (flush)                state_next = DRAIN;
            DRAIN:   if (inflight_reg == '0)   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // In-flight counter: issues add, returns subtract, both together cancel
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_reg <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   inflight_reg <= inflight_reg + INF_ONE;
                2'b01:   inflight_reg <= inflight_reg - INF_ONE;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    // ALU drive registers: one-cycle enable pulse, operands hold when idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_en_reg  <= 1'b0;
            alu_cmd_reg <= '0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
        end else begin
            alu_en_reg <= issue;
            if (issue) begin
                alu_cmd_reg <= head_cmd;
                alu_a_reg   <= head_a;
                alu_b_reg   <= head_b;
            end
        end
    end

    // Protocol and credit invariants
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(alu_ready && inflight_reg == '0));
            assert (!(out_push && out_q_full && !res_pop));
            assert (!(issue && tag_q_full && !ret));
            assert (!(ret && tag_q_empty));
            assert (tag_q_count == inflight_reg);
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_issued_reg, stat_completed_reg, stat_flushed_reg;

    assign stat_issued    = stat_issued_reg;
    assign stat_completed = stat_completed_reg;
    assign stat_flushed   = stat_flushed_reg;

    // Free-running statistics; only reset clears them
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_issued_reg    <= '0;
            stat_completed_reg <= '0;
            stat_flushed_reg   <= '0;
        end else begin
            if (alu_en_reg) stat_issued_reg    <= stat_issued_reg + 32'd1;
            if (res_pop)    stat_completed_reg <= stat_completed_reg + 32'd1;
            if (flush_now)
                stat_flushed_reg <= stat_flushed_reg + 32'(in_q_count) + 32'(inflight_reg)
                                    + 32'(out_q_count) - 32'(res_pop);
        end
    end
`endif

endmodule
